// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// shifting of an 8-bit command with odd parity and stop bit, ack check and
// a watchdog covering everything after the inhibit phase.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES  = 2864,
    parameter int WATCHDOG_CYCLES = 429540
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int IW = (INHIBIT_CYCLES  < 1) ? 1 : $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = (WATCHDOG_CYCLES < 1) ? 1 : $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d;
    logic [3:0]    bit_q, bit_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [WW-1:0] wd_q, wd_d;

    logic          clk_s, dat_s, fe, wd_run;
    logic [9:0]    frame;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    // Falling edge of the synchronised clock line, valid for one cycle.
    assign fe    = clk_prev_q & ~clk_s;
    // Bits presented after each device falling edge: data LSB first, parity, stop.
    assign frame = {1'b1, par_q, byte_q};

    // Next-state, counters and pin drive; the watchdog overrides everything.
    always_comb begin
        state_d    = state_q;
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_s;
        byte_d     = byte_q;
        par_d      = par_q;
        bit_d      = bit_q;
        inh_d      = inh_q;
        wd_d       = wd_q;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        error      = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;

        wd_run = (state_q == S_RTS) || (state_q == S_SHIFT) ||
                 (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
        if (wd_run && (wd_q != '0)) wd_d = wd_q - WW'(1);

        case (state_q)
            S_IDLE: begin
                if (send) begin
                    byte_d  = data;
                    par_d   = ~^data;
                    bit_d   = 4'd0;
                    inh_d   = IW'(INHIBIT_CYCLES);
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                // Leave on the edge where the count reaches zero, so the clock
                // line is held for exactly INHIBIT_CYCLES cycles.
                if (inh_q > IW'(1)) begin
                    inh_d = inh_q - IW'(1);
                end else begin
                    inh_d   = '0;
                    wd_d    = WW'(WATCHDOG_CYCLES);
                    state_d = S_RTS;
                end
            end
            S_RTS: begin
                ps2_dat_oe = 1'b1;
                if (fe) begin
                    bit_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ps2_dat_oe = ~frame[bit_q];
                if (fe) begin
                    bit_d = bit_q + 4'd1;
                    // Parity was on the line; this edge presents the stop bit,
                    // which is simply the released line in ACK.
                    if (bit_q == 4'd8) state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (fe) begin
                    if (dat_s) begin
                        error   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wd_run && (wd_q == '0)) begin
            done       = 1'b0;
            error      = 1'b1;
            ps2_clk_oe = 1'b0;
            ps2_dat_oe = 1'b0;
            state_d    = S_IDLE;
        end
    end

    // State and datapath registers; synchronisers reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            byte_q     <= '0;
            par_q      <= 1'b0;
            bit_q      <= '0;
            inh_q      <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            bit_q      <= bit_d;
            inh_q      <= inh_d;
            wd_q       <= wd_d;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the
// transmitter and compares them with frames built from the byte arithmetically.
module tb_ps2_host_tx;
    localparam int INH = 2864;
    localparam int WD  = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy, done, error, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;

    // Wired-AND of host and device drivers on the two open-drain lines.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .WATCHDOG_CYCLES(WD)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .send       (send),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) n_done <= n_done + 1;
        if (error === 1'b1) n_err <= n_err + 1;
        if (done === 1'b1 && error === 1'b1) n_both <= n_both + 1;
    end

    typedef struct {
        logic [7:0]  d;
        bit          ack;
        logic [10:0] frame;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic do_send(input logic [7:0] d);
        data = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_rts(output bit ok);
        int t;
        t = 0;
        while (!(ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0) && t < INH + 100) begin
            @(negedge clk);
            t++;
        end
        ok = (ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0);
    endtask

    task automatic fe_pulse();
        dev_clk = 1'b0;
        tick(10);
        dev_clk = 1'b1;
        tick(10);
    endtask

    // Device side: waits for request-to-send, clocks 10 bits out sampling on
    // each rising edge, then clocks the ack edge with data low (ack) or high.
    task automatic device(input bit ack, output logic [10:0] fr, output int lat, output bit ok);
        logic prev;
        bit   rts;
        fr  = '0;
        lat = -1;
        ok  = 1'b0;
        wait_rts(rts);
        if (!rts) return;
        tick(5);
        fr[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            prev    = ps2_dat_oe;
            dev_clk = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (k == 1 && lat < 0 && ps2_dat_oe !== prev) lat = c;
            end
            dev_clk = 1'b1;
            fr[k]   = ps2_dat_in;
            tick(10);
        end
        if (ack) dev_dat = 1'b0;
        tick(3);
        dev_clk = 1'b0;
        tick(10);
        dev_clk = 1'b1;
        tick(3);
        dev_dat = 1'b1;
        ok = 1'b1;
    endtask

    task automatic transfer(input logic [7:0] d, input bit ack, input logic [10:0] exp_fr,
                            input bit exp_done, input bit exp_err, input string tag);
        logic [10:0] fr;
        int          lat, w, t, d0, e0, b0;
        bit          ok;
        d0 = n_done; e0 = n_err; b0 = n_both;
        do_send(d);
        chk({tag, "_busy_rise"}, busy, 1);
        w = 0;
        while (ps2_clk_oe === 1'b1 && w < INH + 50) begin
            w++;
            @(negedge clk);
        end
        chk({tag, "_inhibit_width"}, w, INH);
        chk({tag, "_rts_dat_oe"}, ps2_dat_oe, 1);
        device(ack, fr, lat, ok);
        chk({tag, "_device_ok"}, ok, 1);
        chk({tag, "_frame"}, fr, exp_fr);
        if (d[0]) chk({tag, "_fe_latency"}, lat, 3);
        else      chk({tag, "_fe_latency"}, lat, -1);
        t = 0;
        while (busy === 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_done_cnt"}, n_done - d0, exp_done);
        chk({tag, "_err_cnt"}, n_err - e0, exp_err);
        chk({tag, "_both"}, n_both - b0, 0);
    endtask

    initial begin
        int  k, d0, e0;
        bit  ok;

        // Reset state
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        reset = 1'b0;
        tick(2);

        // Table of directed and random bytes with their model expectations
        vecs[0] = '{8'hF4, 1'b1, model_frame(8'hF4), 1'b1, 1'b0};
        vecs[1] = '{8'hED, 1'b1, model_frame(8'hED), 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, model_frame(8'hFF), 1'b1, 1'b0};
        vecs[3] = '{8'hF3, 1'b1, model_frame(8'hF3), 1'b1, 1'b0};
        vecs[4] = '{8'h55, 1'b0, model_frame(8'h55), 1'b0, 1'b1};
        for (int i = 5; i < 10; i++) begin
            vecs[i].d        = 8'($urandom_range(0, 255));
            vecs[i].ack      = ($urandom_range(0, 3) != 0);
            vecs[i].frame    = model_frame(vecs[i].d);
            vecs[i].exp_done = vecs[i].ack;
            vecs[i].exp_err  = !vecs[i].ack;
        end
        chk("model_f4", model_frame(vecs[0].d), 11'b1_0_11110100_0);
        chk("model_ed_parity", vecs[1].frame[9], 1);

        for (int i = 0; i < 10; i++) begin
            transfer(vecs[i].d, vecs[i].ack, vecs[i].frame, vecs[i].exp_done,
                     vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Stray send with 0x00 during SHIFT, then a send right after busy falls
        fork
            transfer(8'h3C, 1'b1, model_frame(8'h3C), 1'b1, 1'b0, "inflight");
            begin
                tick(1 + INH + 5 + 60);
                data = 8'h00;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        transfer(8'hA7, 1'b1, model_frame(8'hA7), 1'b1, 1'b0, "turnaround");

        // Watchdog: device never clocks after request-to-send
        do_send(8'hA5);
        wait_rts(ok);
        chk("wd_rts", ok, 1);
        k = 0;
        while (error !== 1'b1 && k < WD + 50) begin
            @(negedge clk);
            k++;
        end
        chk("wd_latency", k, WD);
        chk("wd_clk_oe", ps2_clk_oe, 0);
        chk("wd_dat_oe", ps2_dat_oe, 0);
        chk("wd_done", done, 0);
        chk("wd_busy_last", busy, 1);
        @(negedge clk);
        chk("wd_busy_after", busy, 0);
        chk("wd_error_after", error, 0);
        tick(2);

        // Reset in the middle of SHIFT after four falling edges
        d0 = n_done; e0 = n_err;
        do_send(8'h96);
        wait_rts(ok);
        chk("mid_rts", ok, 1);
        tick(5);
        for (int i = 0; i < 4; i++) fe_pulse();
        chk("mid_bit3_drive", ps2_dat_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_clk_oe", ps2_clk_oe, 0);
        chk("mid_dat_oe", ps2_dat_oe, 0);
        chk("mid_busy", busy, 0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) fe_pulse();
        tick(20);
        chk("mid_no_done", n_done - d0, 0);
        chk("mid_no_err", n_err - e0, 0);
        chk("mid_idle_busy", busy, 0);
        chk("mid_idle_oe", {ps2_clk_oe, ps2_dat_oe}, 0);

        // Back in service after the reset
        transfer(8'hF4, 1'b1, model_frame(8'hF4), 1'b1, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) from the FPGATED core to the attached PS/2 keyboard over the shared open-drain clock and data lines. It is the outbound counterpart of the scancode/receiveflag path that feeds the C16 key matrix, and sits beside the PS/2 receiver on the same pins. It implements the full host request-to-send sequence, device-clocked bit shifting, odd parity, acknowledge check and watchdog.

## Interface
Parameters:
- INHIBIT_CYCLES, 2864: clk cycles the PS/2 clock line is held low before request-to-send (100 µs at 28.636 MHz).
- WATCHDOG_CYCLES, 429540: maximum clk cycles from end of inhibit to completion (15 ms).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- data  input  8  byte to send; sampled on the accepted send cycle.
- send  input  1  one-cycle request strobe.
- busy  output  1  high from the cycle after an accepted send until the done/error cycle, inclusive.
- done  output  1  one-cycle pulse: byte sent and acknowledged.
- error  output  1  one-cycle pulse: missing ack or watchdog expiry.
- ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous).
- ps2_dat_in  input  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release.
- ps2_dat_oe  output  1  1 = pull PS/2 data low; 0 = release.

## Operation
- Inputs pass through a 2-FF synchronizer. A falling edge of ps2_clk is registered when the synced value goes 1→0 (one-cycle fe strobe).
- Shift frame, 10 bits, LSB first: data[7:0], odd parity (1 when data has an even number of ones), stop (1). Data line is driven low for 0 bits and released for 1 bits.
- States:
  - IDLE: both oe = 0. An accepted send latches data and parity, loads the counter with INHIBIT_CYCLES, and moves to INHIBIT.
  - INHIBIT: clk_oe = 1, dat_oe = 0. The counter reaches 0, then the block moves to RTS with watchdog = WATCHDOG_CYCLES.
  - RTS: clk_oe = 0, dat_oe = 1 (start bit). On fe it presents bit index 0 and moves to SHIFT.
  - SHIFT: on each fe it presents the next frame bit. On the fe that presents the stop bit, dat_oe = 0 and the block moves to ACK.
  - ACK: on fe it samples synced data. 0 moves to WAIT_IDLE. 1 pulses error and returns to IDLE.
  - WAIT_IDLE: when both synced lines are 1, it pulses done and returns to IDLE.
- The watchdog decrements each cycle in RTS/SHIFT/ACK/WAIT_IDLE. At 0 it pulses error and goes to IDLE; both oe are released that same cycle.
- send is ignored when not in IDLE, and in the same cycle as a done/error pulse.
- The bit counter is 4 bits. Inhibit and watchdog counters are $clog2(param+1) bits and never wrap.
- reset at any point: state IDLE, both oe 0, busy/done/error 0, counters cleared. The lines are released on the cycle after reset is sampled.

## Timing
- Reset values: busy 0, done 0, error 0, ps2_clk_oe 0, ps2_dat_oe 0.
- send sampled at edge N: busy and clk_oe rise at N+1. clk_oe stays high for exactly INHIBIT_CYCLES cycles. Then clk_oe falls and dat_oe rises on the same edge.
- Pin falling edge to dat_oe change: 3 clk cycles (2 sync + edge register). The device samples on the rising edge, at least 15 µs later.
- ACK sample point: the 11th fe after RTS (start bit counts as bit 0 of the device's count).
- done/error are asserted together with the final busy cycle. busy drops on the next edge, and they are never both high.
- Minimum turnaround: a new send is accepted the cycle after busy falls.

## Test plan
- Reset mid-SHIFT (after 4 fe): next cycle clk_oe = 0, dat_oe = 0, busy = 0. No done or error pulse follows.
- send data = 0xF4, device model clocks 11 falling edges and acks: the model captures start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1. done pulses once, busy low afterwards.
- send data = 0xED: the model captures parity 1. Measure clk_oe low-drive width = 2864 cycles exactly.
- Device leaves data high at the ack edge: error = 1 for one cycle, done stays 0, state returns to IDLE.
- Device never clocks after RTS: error fires exactly WATCHDOG_CYCLES cycles after dat_oe rose, and both oe go 0 that cycle.
- send pulsed again during SHIFT with data = 0x00: the transfer in flight is unaffected and still sends its original byte. The 0x00 is never transmitted. A send one cycle after busy falls is accepted.
